// File: rtl/seq_mag_comp_if.sv
// -----------------------------------------------------------------------------
// seq_mag_comp_if
//
// Request/result bundle for the sequential magnitude comparator.
//
// Signals:
//   start  request; sampled by the comparator only while busy = 0
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   busy   comparison in progress
//   done   single-cycle pulse marking a new result
//   agb    A greater than B
//   alb    A less than B
//   aeb    A equal to B
//
// Modports:
//   master  requester side (drives start/a/b, observes results)
//   slave   comparator side
//
// WIDTH must match the WIDTH of the attached seq_mag_comp instance.
// -----------------------------------------------------------------------------
interface seq_mag_comp_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             agb;
   logic             alb;
   logic             aeb;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  agb,
      input  alb,
      input  aeb
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output agb,
      output alb,
      output aeb
   );

endinterface

// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
//
// Parametrised sequential magnitude comparator. Operands are captured on an
// accepted start and compared MSB-first, DIGIT bits per clock. The comparison
// stops at the first differing digit, so latency ranges from 1 cycle (MSB
// digit differs) to NCYC = WIDTH/DIGIT cycles (equal, or only the LSB digit
// differs). A new start is accepted in the cycle done is high.
//
// Parameters:
//   WIDTH  operand width; an integer multiple of DIGIT and at least 2
//   DIGIT  bits compared per clock
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any comparison without done
//   bus    seq_mag_comp_if.slave (start, a, b, busy, done, agb, alb, aeb)
//
// Build option:
//   SEQ_MAG_COMP_SIGNED_EN  when defined, operands are two's complement. The
//                           sign bit is inverted at capture so the
//                           offset-binary values order correctly under the
//                           unsigned digit compare. Latency is unchanged.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seq_mag_comp #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_mag_comp_if.slave bus
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int NCYC = WIDTH / DIGIT;
   // Keep the index at least one bit wide so NCYC = 1 still elaborates.
   localparam int IDXW = (NCYC > 1) ? $clog2(NCYC) : 1;

   localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NCYC - 1);
   localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

`ifdef SEQ_MAG_COMP_SIGNED_EN
   // Flip the sign bit: two's complement -> offset binary.
   localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
   localparam logic [WIDTH-1:0] SIGN_FLIP = {WIDTH{1'b0}};
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Digit compare outcome encoding
   localparam logic [1:0] CMP_EQ = 2'b00;
   localparam logic [1:0] CMP_GT = 2'b01;
   localparam logic [1:0] CMP_LT = 2'b10;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------

   // Select digit number sel (0 = least significant) from word w. Written as
   // an explicit mux so the index math never leaves the IDXW domain.
   function automatic logic [DIGIT-1:0] get_digit(
      input logic [WIDTH-1:0] w,
      input logic [IDXW-1:0]  sel
   );
      logic [DIGIT-1:0] res;
      res = {DIGIT{1'b0}};
      for (int k = 0; k < NCYC; k++) begin
         if (sel == IDXW'(k)) begin
            res = w[k*DIGIT +: DIGIT];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Unsigned compare of two digits, returning one of the CMP_* codes.
   function automatic logic [1:0] cmp_digit(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y
   );
      logic [1:0] res;
      if (x > y) begin
         res = CMP_GT;
      end else if (x < y) begin
         res = CMP_LT;
      end else begin
         res = CMP_EQ;
      end
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]       state_r;
   logic [IDXW-1:0]  idx_r;
   logic [WIDTH-1:0] ra_r;
   logic [WIDTH-1:0] rb_r;
   logic             busy_r;
   logic             done_r;
   logic             agb_r;
   logic             alb_r;
   logic             aeb_r;

   // Next-state values
   logic [0:0]       state_s;
   logic [IDXW-1:0]  idx_s;
   logic [WIDTH-1:0] ra_s;
   logic [WIDTH-1:0] rb_s;
   logic             busy_s;
   logic             done_s;
   logic             agb_s;
   logic             alb_s;
   logic             aeb_s;

   // Current digit pair and its compare outcome
   logic [DIGIT-1:0] dig_a_s;
   logic [DIGIT-1:0] dig_b_s;
   logic [1:0]       cmp_s;

   // Pick the digit pair addressed by the index and compare it.
   always_comb begin
      dig_a_s = get_digit(ra_r, idx_r);
      dig_b_s = get_digit(rb_r, idx_r);
      cmp_s   = cmp_digit(dig_a_s, dig_b_s);
   end

   // Next-state logic: accept in IDLE, one digit per cycle in RUN.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      ra_s    = ra_r;
      rb_s    = rb_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      agb_s   = agb_r;
      alb_s   = alb_r;
      aeb_s   = aeb_r;

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_RUN;
               ra_s    = bus.a ^ SIGN_FLIP;
               rb_s    = bus.b ^ SIGN_FLIP;
               idx_s   = IDX_TOP;
               busy_s  = 1'b1;
               agb_s   = 1'b0;
               alb_s   = 1'b0;
               aeb_s   = 1'b0;
            end else begin
               busy_s  = 1'b0;
            end
         end

         ST_RUN: begin
            // start is ignored here: requests are not queued while busy.
            case (cmp_s)
               CMP_GT: begin
                  agb_s   = 1'b1;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  state_s = ST_IDLE;
               end
               CMP_LT: begin
                  alb_s   = 1'b1;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  state_s = ST_IDLE;
               end
               default: begin
                  if (idx_r == IDX_ZERO) begin
                     // Every digit matched.
                     aeb_s   = 1'b1;
                     done_s  = 1'b1;
                     busy_s  = 1'b0;
                     state_s = ST_IDLE;
                  end else begin
                     idx_s   = idx_r - IDX_ONE;
                  end
               end
            endcase
         end

         default: begin
            // Unreachable encoding: recover to a clean idle.
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            agb_s   = 1'b0;
            alb_s   = 1'b0;
            aeb_s   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any comparison silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= IDX_ZERO;
         ra_r    <= {WIDTH{1'b0}};
         rb_r    <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         agb_r   <= 1'b0;
         alb_r   <= 1'b0;
         aeb_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         ra_r    <= ra_s;
         rb_r    <= rb_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         agb_r   <= agb_s;
         alb_r   <= alb_s;
         aeb_r   <= aeb_s;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.agb  = agb_r;
   assign bus.alb  = alb_r;
   assign bus.aeb  = aeb_r;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
//
// Directed bench for seq_mag_comp at WIDTH=8, DIGIT=2. A table of operand
// pairs with hand-computed flags and latency is applied in a loop, followed by
// hand-written sequences for start-while-busy, start in the done cycle and
// reset in the middle of a comparison. Define SEQ_MAG_COMP_SIGNED_EN for both
// bench and RTL to check the signed build.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_mag_comp_if #(.WIDTH(WIDTH)) ifc ();

   seq_mag_comp #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] flags;   // {agb, alb, aeb}
      int         lat;     // edges from accept to done
   } vec_t;

   localparam logic [2:0] F_GT = 3'b100;
   localparam logic [2:0] F_LT = 3'b010;
   localparam logic [2:0] F_EQ = 3'b001;

   int   n_vec    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;
   vec_t tbl [12];

   // Count every done cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (ifc.done === 1'b1) begin
         done_cnt <= done_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] flags_now();
      return {29'd0, ifc.agb, ifc.alb, ifc.aeb};
   endfunction

   // Wait for done, sampling 1 time unit after each edge; returns edge count
   // or 99 if it never arrives.
   task automatic wait_done(output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ifc.done === 1'b1) seen = 1'b1;
      end
      if (!seen) cyc = 99;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      int d0;
      @(negedge clk);
      ifc.a     = v.a;
      ifc.b     = v.b;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("%s busy_at_accept", tag), {31'd0, ifc.busy}, 32'd1);
      chk($sformatf("%s flags_cleared", tag), flags_now(), 32'd0);
      d0 = done_cnt;
      @(negedge clk);
      ifc.start = 1'b0;
      wait_done(cyc);
      chk($sformatf("%s latency", tag), cyc, v.lat);
      chk($sformatf("%s flags", tag), flags_now(), {29'd0, v.flags});
      chk($sformatf("%s busy_in_done", tag), {31'd0, ifc.busy}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("%s done_pulse_width", tag), {31'd0, ifc.done}, 32'd0);
      chk($sformatf("%s done_count", tag), done_cnt - d0, 32'd1);
   endtask

   initial begin
      int cyc;
      int d0;

      ifc.start = 1'b0;
      ifc.a     = 8'h00;
      ifc.b     = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, ifc.busy}, 32'd0);
      chk("reset done", {31'd0, ifc.done}, 32'd0);
      chk("reset flags", flags_now(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Digits listed MSB-first in the comments.
`ifdef SEQ_MAG_COMP_SIGNED_EN
      tbl[0]  = '{8'hA5, 8'h25, F_LT, 1};  // negative vs positive
      tbl[3]  = '{8'h80, 8'h01, F_LT, 1};  // -128 < 1
`else
      tbl[0]  = '{8'hA5, 8'h25, F_GT, 1};  // 10.. vs 00..
      tbl[3]  = '{8'h80, 8'h01, F_GT, 1};  // 128 > 1
`endif
      tbl[1]  = '{8'h3C, 8'h3C, F_EQ, 4};
      tbl[2]  = '{8'h40, 8'h41, F_LT, 4};  // differs in LSB digit only
      tbl[4]  = '{8'h00, 8'h00, F_EQ, 4};
      tbl[5]  = '{8'hFF, 8'hFF, F_EQ, 4};
      tbl[6]  = '{8'h1C, 8'h18, F_GT, 3};  // 00 01 11 00 vs 00 01 10 00
      tbl[7]  = '{8'h34, 8'h38, F_LT, 3};  // 00 11 01 00 vs 00 11 10 00
      tbl[8]  = '{8'h12, 8'h22, F_LT, 2};  // 00 01 .. vs 00 10 ..
      tbl[9]  = '{8'h7F, 8'h7E, F_GT, 4};
      tbl[10] = '{8'hC0, 8'hF0, F_LT, 2};  // 11 00 .. vs 11 11 ..
      tbl[11] = '{8'h02, 8'h01, F_GT, 4};

      for (int i = 0; i < 12; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Start while busy is ignored, then start accepted in the done cycle.
      @(negedge clk);
      ifc.a     = 8'h00;
      ifc.b     = 8'h00;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      d0 = done_cnt;
      @(negedge clk);
      ifc.a = 8'hFF;                 // second request, start still high
      @(posedge clk);
      #1;
      chk("busy_start busy", {31'd0, ifc.busy}, 32'd1);
      @(negedge clk);
      ifc.start = 1'b0;
      wait_done(cyc);
      chk("busy_start latency", cyc + 1, 32'd4);
      chk("busy_start flags", flags_now(), {29'd0, F_EQ});
      // Still in the done cycle: issue the next request.
      @(negedge clk);
      ifc.a     = 8'h12;
      ifc.b     = 8'h22;
      ifc.start = 1'b1;
      @(posedge clk);
      #1;
      chk("done_cycle_start busy", {31'd0, ifc.busy}, 32'd1);
      chk("done_cycle_start done", {31'd0, ifc.done}, 32'd0);
      chk("done_cycle_start flags_cleared", flags_now(), 32'd0);
      chk("busy_start done_count", done_cnt - d0, 32'd1);
      @(negedge clk);
      ifc.start = 1'b0;
      wait_done(cyc);
      chk("done_cycle_start latency", cyc, 32'd2);
      chk("done_cycle_start flags", flags_now(), {29'd0, F_LT});

      // Reset two cycles into an equal-operand comparison.
      @(negedge clk);
      ifc.a     = 8'h3C;
      ifc.b     = 8'h3C;
      ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b0;
      d0 = done_cnt;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("midrst busy_before", {31'd0, ifc.busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", {31'd0, ifc.busy}, 32'd0);
      chk("midrst done", {31'd0, ifc.done}, 32'd0);
      chk("midrst flags", flags_now(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst no_done", done_cnt - d0, 32'd0);
      chk("midrst flags_after", flags_now(), 32'd0);
      run_vec(tbl[1], "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
